// File: rtl/nv_nvdla_cacc_dlv_credit_sched.sv
// CACC delivery-buffer credit scheduler: admits stripes against free entries
// and sequences one layer through IDLE/RUN/DRAIN/DONE.
module nv_nvdla_cacc_dlv_credit_sched #(
   parameter int DEPTH  = 32,
   parameter int CNT_W  = 6,
   parameter int SIZE_W = 6
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic              reg2dp_op_en,
   input  logic              stripe_req_valid,
   input  logic [SIZE_W-1:0] stripe_req_size,
   input  logic              stripe_req_layer_end,
   output logic              stripe_req_ready,
   input  logic              dlv_pop,
   output logic              wait_for_op_en,
   output logic [CNT_W-1:0]  credit_avl,
   output logic              layer_drained,
   output logic              err_size,
   output logic              err_credit_ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] credit_q, credit_d;
   logic             err_size_q, err_size_d;
   logic             err_ovf_q, err_ovf_d;

   logic [CNT_W:0]   size_w;
   logic [CNT_W:0]   credit_w;
   logic [CNT_W:0]   credit_nxt;
   logic             size_ok;
   logic             ready;
   logic             accept;
   logic             ovf;

   assign size_w   = (CNT_W+1)'(stripe_req_size);
   assign credit_w = {1'b0, credit_q};
   assign size_ok  = (size_w != '0) && (size_w <= DEPTH_W);

   // Grant compares against the registered count only.
   assign ready  = (state_q == S_RUN) && size_ok && (credit_w >= size_w);
   assign accept = stripe_req_valid && ready;
   assign ovf    = dlv_pop && !accept && (credit_w == DEPTH_W);

   assign credit_nxt = credit_w
                     - (accept ? size_w : '0)
                     + (dlv_pop ? (CNT_W+1)'(1) : '0);

   always_comb begin
      state_d    = state_q;
      credit_d   = ovf ? DEPTH_W[CNT_W-1:0] : credit_nxt[CNT_W-1:0];
      err_size_d = err_size_q;
      err_ovf_d  = err_ovf_q || ovf;
      if (stripe_req_valid && (state_q == S_RUN) && !size_ok)
         err_size_d = 1'b1;
      unique case (state_q)
         S_IDLE:  if (reg2dp_op_en) state_d = S_RUN;
         S_RUN:   if (accept && stripe_req_layer_end) state_d = S_DRAIN;
         S_DRAIN: if (ovf || credit_nxt == DEPTH_W) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q    <= S_IDLE;
         credit_q   <= DEPTH_W[CNT_W-1:0];
         err_size_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         err_size_q <= err_size_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   assign stripe_req_ready = ready;
   assign wait_for_op_en   = (state_q == S_IDLE);
   assign layer_drained    = (state_q == S_DONE);
   assign credit_avl       = credit_q;
   assign err_size         = err_size_q;
   assign err_credit_ovf   = err_ovf_q;

endmodule
